// File: rtl/ps2_kbmat.sv
// PS/2 set-2 keyboard receiver that tracks a 64-bit Z88 key matrix (bit = row*8+col, 1 = held).
// Frames are received on the filtered PS/2 clock; decoded make/break codes update kbmat two cycles after acceptance.
module ps2_kbmat #(
    parameter int unsigned FILT    = 4,
    parameter int unsigned TIMEOUT = 9830
) (
    input  logic        mck,
    input  logic        rin_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [63:0] kbmat,
    output logic        key_stb,
    output logic        rx_err
);

    localparam int unsigned FW = $clog2(FILT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      clk_sync, dat_sync;
    logic            clk_s, dat_s;
    logic            filt_clk, fall_e;
    logic [FW-1:0]   filt_cnt;
    logic [7:0]      sr;
    logic [2:0]      bitcnt;
    logic            par;
    logic [TW-1:0]   to_cnt;
    logic            timeout, byte_ok, frame_err;
    logic            ext, brk;
    logic            s1_upd, s1_clr_all, s1_brk;
    logic [5:0]      s1_idx;
    logic [6:0]      map;

    // {valid, idx} for a set-2 code; bit 8 of code is the E0 prefix.
    function automatic logic [6:0] z88_keymap(input logic [8:0] code);
        logic [6:0] m;
        m = '0;
        case (code)
            9'h066: m = {1'b1, 6'd0};
            9'h05A: m = {1'b1, 6'd1};
            9'h036: m = {1'b1, 6'd2};
            9'h035: m = {1'b1, 6'd3};
            9'h033: m = {1'b1, 6'd4};
            9'h031: m = {1'b1, 6'd5};
            9'h03D: m = {1'b1, 6'd6};
            9'h03E: m = {1'b1, 6'd7};
            9'h05D: m = {1'b1, 6'd8};
            9'h02E: m = {1'b1, 6'd9};
            9'h02C: m = {1'b1, 6'd10};
            9'h034: m = {1'b1, 6'd11};
            9'h032: m = {1'b1, 6'd12};
            9'h03C: m = {1'b1, 6'd13};
            9'h043: m = {1'b1, 6'd14};
            9'h03B: m = {1'b1, 6'd15};
            9'h055: m = {1'b1, 6'd16};
            9'h025: m = {1'b1, 6'd17};
            9'h02D: m = {1'b1, 6'd18};
            9'h02B: m = {1'b1, 6'd19};
            9'h02A: m = {1'b1, 6'd20};
            9'h044: m = {1'b1, 6'd21};
            9'h042: m = {1'b1, 6'd22};
            9'h046: m = {1'b1, 6'd23};
            9'h04E: m = {1'b1, 6'd24};
            9'h026: m = {1'b1, 6'd25};
            9'h024: m = {1'b1, 6'd26};
            9'h023: m = {1'b1, 6'd27};
            9'h021: m = {1'b1, 6'd28};
            9'h04D: m = {1'b1, 6'd29};
            9'h03A: m = {1'b1, 6'd30};
            9'h045: m = {1'b1, 6'd31};
            9'h05B: m = {1'b1, 6'd32};
            9'h01E: m = {1'b1, 6'd33};
            9'h01D: m = {1'b1, 6'd34};
            9'h022: m = {1'b1, 6'd35};
            9'h04B: m = {1'b1, 6'd36};
            9'h016: m = {1'b1, 6'd37};
            9'h015: m = {1'b1, 6'd38};
            9'h01C: m = {1'b1, 6'd39};
            9'h054: m = {1'b1, 6'd40};
            9'h01A: m = {1'b1, 6'd41};
            9'h04C: m = {1'b1, 6'd42};
            9'h041: m = {1'b1, 6'd43};
            9'h00D: m = {1'b1, 6'd44};
            9'h052: m = {1'b1, 6'd45};
            9'h012: m = {1'b1, 6'd46};
            9'h049: m = {1'b1, 6'd47};
            9'h04A: m = {1'b1, 6'd48};
            9'h058: m = {1'b1, 6'd49};
            9'h16B: m = {1'b1, 6'd50};
            9'h174: m = {1'b1, 6'd51};
            9'h005: m = {1'b1, 6'd52};
            9'h006: m = {1'b1, 6'd53};
            9'h014: m = {1'b1, 6'd54};
            9'h076: m = {1'b1, 6'd55};
            9'h011: m = {1'b1, 6'd56};
            9'h11F: m = {1'b1, 6'd57};
            9'h175: m = {1'b1, 6'd58};
            9'h172: m = {1'b1, 6'd59};
            9'h00E: m = {1'b1, 6'd60};
            9'h029: m = {1'b1, 6'd61};
            9'h004: m = {1'b1, 6'd62};
            9'h059: m = {1'b1, 6'd63};
            default: m = '0;
        endcase
        return m;
    endfunction

    always_ff @(posedge mck) begin
        if (!rin_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // A new clock level is taken only after FILT consecutive differing samples.
    always_ff @(posedge mck) begin
        if (!rin_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall_e   <= 1'b0;
        end else begin
            fall_e <= 1'b0;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT - 1)) begin
                filt_cnt <= '0;
                filt_clk <= clk_s;
                fall_e   <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT));

    always_ff @(posedge mck) begin
        if (!rin_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        byte_ok   = 1'b0;
        frame_err = 1'b0;
        if (timeout) begin
            state_nxt = IDLE;
            frame_err = 1'b1;
        end else if (fall_e) begin
            case (state)
                IDLE: begin
                    if (!dat_s) state_nxt = DATA;
                    else        frame_err = 1'b1;
                end
                DATA:    if (bitcnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (dat_s && (^{sr, par})) byte_ok   = 1'b1;
                    else                       frame_err = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge mck) begin
        if (!rin_n) begin
            sr     <= '0;
            bitcnt <= '0;
            par    <= 1'b0;
            to_cnt <= '0;
        end else begin
            if (fall_e || state == IDLE) begin
                to_cnt <= '0;
            end else if (!timeout) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (fall_e && !timeout) begin
                case (state)
                    IDLE:   bitcnt <= '0;
                    DATA: begin
                        sr     <= {dat_s, sr[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                    end
                    PARITY: par <= dat_s;
                    default: ;
                endcase
            end
        end
    end

    assign map = z88_keymap({ext, sr});

    // Stage 1 registers the lookup at T+1; stage 2 applies it to kbmat at T+2.
    always_ff @(posedge mck) begin
        if (!rin_n) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            rx_err     <= 1'b0;
            s1_upd     <= 1'b0;
            s1_clr_all <= 1'b0;
            s1_brk     <= 1'b0;
            s1_idx     <= '0;
            kbmat      <= '0;
            key_stb    <= 1'b0;
        end else begin
            rx_err     <= frame_err;
            s1_upd     <= 1'b0;
            s1_clr_all <= 1'b0;
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_ok) begin
                case (sr)
                    8'hE0: ext <= 1'b1;
                    8'hF0: brk <= 1'b1;
                    8'hAA, 8'hFC: begin
                        s1_clr_all <= 1'b1;
                        ext        <= 1'b0;
                        brk        <= 1'b0;
                    end
                    default: begin
                        s1_upd <= map[6];
                        s1_idx <= map[5:0];
                        s1_brk <= brk;
                        ext    <= 1'b0;
                        brk    <= 1'b0;
                    end
                endcase
            end

            key_stb <= 1'b0;
            if (s1_clr_all) begin
                kbmat   <= '0;
                key_stb <= 1'b1;
            end else if (s1_upd && (kbmat[s1_idx] == s1_brk)) begin
                kbmat[s1_idx] <= ~s1_brk;
                key_stb       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbmat.sv
// Directed bench for ps2_kbmat: drives PS/2 frames and checks kbmat, key_stb and rx_err pulse counts.
module tb_ps2_kbmat;

    localparam int unsigned HALF = 20;
    localparam int unsigned TOUT = 500;

    logic        mck = 1'b0;
    logic        rin_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [63:0] kbmat;
    logic        key_stb;
    logic        rx_err;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int s0, e0;

    ps2_kbmat #(.FILT(4), .TIMEOUT(TOUT)) dut (
        .mck     (mck),
        .rin_n   (rin_n),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .kbmat   (kbmat),
        .key_stb (key_stb),
        .rx_err  (rx_err)
    );

    always #5 mck = ~mck;

    always @(negedge mck) begin
        if (key_stb) stb_cnt++;
        if (rx_err) err_cnt++;
        if (key_stb && rx_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge mck);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic snap();
        s0 = stb_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        logic [63:0] exp_m;

        wait_cyc(4);
        check("reset_kbmat", kbmat, 64'd0);
        check("reset_stb", {63'd0, key_stb}, 64'd0);
        check("reset_err", {63'd0, rx_err}, 64'd0);
        rin_n = 1'b1;
        wait_cyc(10);

        // N make then break
        snap();
        send(8'h31, 1'b0);
        check("n_make", kbmat, 64'd1 << 5);
        check("n_make_stb", 64'(stb_cnt - s0), 64'd1);
        check("n_make_err", 64'(err_cnt - e0), 64'd0);
        snap();
        send(8'hF0, 1'b0);
        send(8'h31, 1'b0);
        check("n_break", kbmat, 64'd0);
        check("n_break_stb", 64'(stb_cnt - s0), 64'd1);

        // extended UP, then plain 75 and 72 must not use the ext flag
        snap();
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        check("up_make", kbmat, 64'd1 << 58);
        check("up_make_stb", 64'(stb_cnt - s0), 64'd1);
        snap();
        send(8'h75, 1'b0);
        send(8'h72, 1'b0);
        check("plain75_kbmat", kbmat, 64'd1 << 58);
        check("plain75_stb", 64'(stb_cnt - s0), 64'd0);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h75, 1'b0);
        check("up_break", kbmat, 64'd0);

        // parity error then good frame
        snap();
        send(8'h5A, 1'b1);
        check("badpar_err", 64'(err_cnt - e0), 64'd1);
        check("badpar_kbmat", kbmat, 64'd0);
        check("badpar_stb", 64'(stb_cnt - s0), 64'd0);
        send(8'h5A, 1'b0);
        check("enter_make", kbmat, 64'd1 << 1);
        send(8'hF0, 1'b0);
        send(8'h5A, 1'b0);
        check("enter_break", kbmat, 64'd0);

        // error clears a pending E0: the following 72 stays unmapped
        snap();
        send(8'hE0, 1'b0);
        send(8'h33, 1'b1);
        send(8'h72, 1'b0);
        check("err_clr_ext_kbmat", kbmat, 64'd0);
        check("err_clr_ext_err", 64'(err_cnt - e0), 64'd1);

        // stray clock pulse with data high in IDLE
        snap();
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        wait_cyc(HALF);
        check("start_err", 64'(err_cnt - e0), 64'd1);

        // several keys held, typematic repeats give no strobe
        snap();
        send(8'h12, 1'b0);
        send(8'h1B, 1'b0);
        send(8'h36, 1'b0);
        exp_m = (64'd1 << 46) | (64'd1 << 2);
        check("multi_kbmat", kbmat, exp_m);
        check("multi_stb", 64'(stb_cnt - s0), 64'd2);
        snap();
        for (int i = 0; i < 5; i++) send(8'h36, 1'b0);
        check("repeat_kbmat", kbmat, exp_m);
        check("repeat_stb", 64'(stb_cnt - s0), 64'd0);

        // timeout after 4 data bits
        snap();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_dat = 1'b1;
        wait_cyc(TOUT + 60);
        check("timeout_err", 64'(err_cnt - e0), 64'd1);
        check("timeout_kbmat", kbmat, exp_m);
        send(8'h5A, 1'b0);
        exp_m = exp_m | (64'd1 << 1);
        check("after_to_kbmat", kbmat, exp_m);

        // BAT clears the matrix
        snap();
        send(8'hAA, 1'b0);
        check("bat_kbmat", kbmat, 64'd0);
        check("bat_stb", 64'(stb_cnt - s0), 64'd1);

        // reset in the middle of a frame
        send(8'h12, 1'b0);
        check("lshift_again", kbmat, 64'd1 << 46);
        snap();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rin_n = 1'b0;
        wait_cyc(3);
        check("midrst_kbmat", kbmat, 64'd0);
        rin_n = 1'b1;
        ps2_dat = 1'b1;
        wait_cyc(HALF);
        check("midrst_stb", 64'(stb_cnt - s0), 64'd0);
        check("midrst_err", 64'(err_cnt - e0), 64'd0);
        send(8'h5A, 1'b0);
        check("post_rst_enter", kbmat, 64'd1 << 1);

        check("stb_err_overlap", 64'(both_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
